// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq
//   Sequential multiply-accumulate engine for one neuron. On START it walks
//   BRAM addresses 0..N_WEIGHTS-1, accumulating W*X in signed fixed point.
//   It then adds the bias, rescales by FRAC_BITS with floor rounding,
//   saturates to DATA_W bits, optionally applies ReLU, and pulses DONE.
//
// Ports
//   CLK     : single clock, rising-edge state updates
//   RST     : asynchronous active-high reset
//   START   : job request, sampled only while idle
//   BIAS    : neuron bias, sampled in the output cycle
//   W_DO    : weight BRAM read data (BRAM reads on the falling edge)
//   X_DO    : input-activation BRAM read data (same address as weights)
//   ADDR    : registered shared read address
//   EN      : BRAM read enable, high while accumulating
//   BUSY    : high whenever a job is in progress
//   DONE    : one-cycle pulse, RESULT valid
//   RESULT  : saturated/activated output, held until the next DONE
module neuron_mac_seq #(
  parameter int N_WEIGHTS = 28,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int RELU_EN   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] BIAS,
  input  logic [DATA_W-1:0] W_DO,
  input  logic [DATA_W-1:0] X_DO,
  output logic [ADDR_W-1:0] ADDR,
  output logic              EN,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RESULT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHTS - 1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;

  logic signed [2*DATA_W-1:0] w_ext;
  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_sh;
  logic signed [ACC_W-1:0]    sum_b;
  logic signed [ACC_W-1:0]    scaled;
  logic [DATA_W-1:0]          sat_val;
  logic [DATA_W-1:0]          act_val;

  // Operands are sign-extended to full product width so the truncated
  // product equals the exact 2*DATA_W-bit signed product.
  assign w_ext    = {{DATA_W{W_DO[DATA_W-1]}}, W_DO};
  assign x_ext    = {{DATA_W{X_DO[DATA_W-1]}}, X_DO};
  assign prod     = w_ext * x_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  assign bias_sh  = {{(ACC_W-DATA_W-FRAC_BITS){BIAS[DATA_W-1]}}, BIAS,
                     {FRAC_BITS{1'b0}}};
  assign sum_b    = acc + bias_sh;
  assign scaled   = sum_b >>> FRAC_BITS;

  always_comb begin
    sat_val = scaled[DATA_W-1:0];
    if (scaled > SAT_MAX) begin
      sat_val = OUT_MAX;
    end else if (scaled < SAT_MIN) begin
      sat_val = OUT_MIN;
    end
    act_val = sat_val;
    if ((RELU_EN != 0) && sat_val[DATA_W-1]) begin
      act_val = '0;
    end
  end

  assign EN   = (state == S_RUN);
  assign BUSY = (state != S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      ADDR   <= '0;
      acc    <= '0;
      RESULT <= '0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            ADDR  <= '0;
            acc   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Read data for the address issued last cycle is valid here.
          acc <= acc + prod_ext;
          if (ADDR == LAST_ADDR) begin
            state <= S_OUT;
          end else begin
            ADDR <= ADDR + 1'b1;
          end
        end
        S_OUT: begin
          RESULT <= act_val;
          DONE   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
